fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_skid_buf.sv | 36 +++
 rtl/fetch_stage.sv | 189 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: opcode field layout,
// FSM state encodings, default NOP word and a saturating counter helper.
package fetch_stage_pkg;

    localparam int unsigned OPC_W = 5;
    localparam int unsigned OPC_TOP_OFFSET = 1;

    localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        SKID    = 2'd1,
        DISCARD = 2'd2,
        HALTED  = 2'd3
    } fetch_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction (and its pc) that returned
// from memory while the pipeline was stalled.
module fetch_skid_buf
    import fetch_stage_pkg::*;
#(
    parameter int unsigned     IW        = 16,
    parameter int unsigned     AW        = 8,
    parameter logic [IW-1:0]   NOP_INSTR = IW'(NOP_INSTR_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clear,
    input  logic [IW-1:0] instr_in,
    input  logic [AW-1:0] pc_in,
    output logic          valid,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns the pc, drives the imem
// req/ready handshake, honours stall/flush/halt. FETCH_PERF_EN adds counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned   IW        = 16,
    parameter int unsigned   AW        = 8,
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter logic [IW-1:0] NOP_INSTR = IW'(NOP_INSTR_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic [AW-1:0] branch_target,
    input  logic          halt,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic [IW-1:0] imem_rdata,
    output logic          if_id_valid,
    output logic [IW-1:0] if_id_instr,
    output logic [AW-1:0] if_id_pc,
    output logic [4:0]    opcode
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]   perf_fetch_cnt,
    output logic [15:0]   perf_stall_cnt
`endif
);

    fetch_state_t  state;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] tgt;
    logic          halt_pend;
    logic          xfer;
    logic          pending;
    logic          skid_load;
    logic          skid_clear;
    logic          skid_valid;
    logic [IW-1:0] skid_instr;
    logic [AW-1:0] skid_pc;

    assign imem_addr = pc;
    assign opcode    = if_id_instr[IW-OPC_TOP_OFFSET -: OPC_W];

    always_comb begin
        xfer       = imem_req & imem_ready;
        pending    = imem_req & ~imem_ready;
        pc_inc     = pc + AW'(1);
        skid_load  = (state == FETCH) & ~flush & ~halt & ~halt_pend & stall & xfer;
        skid_clear = flush | ((state == SKID) & (halt | ~stall));
    end

    fetch_skid_buf #(
        .IW        (IW),
        .AW        (AW),
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .clear    (skid_clear),
        .instr_in (imem_rdata),
        .pc_in    (pc),
        .valid    (skid_valid),
        .instr    (skid_instr),
        .pc       (skid_pc)
    );

    // imem_addr is the pc itself, so a flush against an outstanding request
    // parks the new target in tgt until DISCARD sees the old transfer finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            tgt         <= RESET_PC;
            halt_pend   <= 1'b0;
            imem_req    <= 1'b0;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (flush) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP_INSTR;
                        halt_pend   <= 1'b0;
                        if (pending) begin
                            tgt   <= branch_target;
                            state <= DISCARD;
                        end else begin
                            pc       <= branch_target;
                            imem_req <= 1'b1;
                        end
                    end else if (halt || halt_pend) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP_INSTR;
                        if (pending) begin
                            halt_pend <= 1'b1;
                        end else begin
                            halt_pend <= 1'b0;
                            imem_req  <= 1'b0;
                            state     <= HALTED;
                        end
                    end else if (stall) begin
                        if (xfer) begin
                            pc       <= pc_inc;
                            imem_req <= 1'b0;
                            state    <= SKID;
                        end
                    end else begin
                        imem_req <= 1'b1;
                        if (xfer) begin
                            if_id_valid <= 1'b1;
                            if_id_instr <= imem_rdata;
                            if_id_pc    <= pc;
                            pc          <= pc_inc;
                        end else begin
                            if_id_valid <= 1'b0;
                            if_id_instr <= NOP_INSTR;
                        end
                    end
                end

                SKID: begin
                    if (flush) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP_INSTR;
                        pc          <= branch_target;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end else if (halt) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP_INSTR;
                        state       <= HALTED;
                    end else if (!stall) begin
                        if_id_valid <= skid_valid;
                        if_id_instr <= skid_instr;
                        if_id_pc    <= skid_pc;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end

                DISCARD: begin
                    if (xfer) begin
                        pc    <= flush ? branch_target : tgt;
                        state <= FETCH;
                    end else if (flush) begin
                        tgt <= branch_target;
                    end
                end

                HALTED: begin
                    if (flush) begin
                        pc       <= branch_target;
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic if_id_load;

    always_comb begin
        if_id_load = ((state == FETCH) & ~flush & ~halt & ~halt_pend & ~stall & xfer)
                   | ((state == SKID) & ~flush & ~halt & ~stall & skid_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (if_id_load)
                perf_fetch_cnt <= sat_inc16(perf_fetch_cnt);
            if (stall && if_id_valid)
                perf_stall_cnt <= sat_inc16(perf_stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected IF/ID contents are queued as
// stimulus is applied and popped when the stage presents a live instruction.
module tb_fetch_stage;

    localparam int unsigned IW = 16;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          halt = 1'b0;
    logic          imem_ready = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          if_id_valid;
    logic [IW-1:0] if_id_instr;
    logic [AW-1:0] if_id_pc;
    logic [4:0]    opcode;
`ifdef FETCH_PERF_EN
    logic [15:0]   perf_fetch_cnt;
    logic [15:0]   perf_stall_cnt;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {a[4:0] ^ 5'h13, 3'b101, a};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_stage #(
        .IW        (IW),
        .AW        (AW),
        .RESET_PC  (8'h00),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .halt          (halt),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .opcode        (opcode)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    task automatic test_reset();
        rst_n = 1'b0;
        imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({imem_req, if_id_valid, if_id_instr, if_id_pc, imem_addr} !== {1'b0, 1'b0, 16'h0000, 8'h00, 8'h00})
            $display("FAIL reset_values: req=%b valid=%b instr=%h pc=%h addr=%h, want 0 0 0000 00 00",
                     imem_req, if_id_valid, if_id_instr, if_id_pc, imem_addr);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({imem_req, if_id_valid, imem_addr} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL reset_req_rise: req=%b valid=%b addr=%h, want 1 0 00", imem_req, if_id_valid, imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        exp_t e;
        for (int i = 0; i < 4; i++) sb.push_back('{pc: 8'(i), instr: mem_word(8'(i))});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            total_cnt++;
            if (if_id_valid !== 1'b1 || if_id_pc !== e.pc || if_id_instr !== e.instr)
                $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h, want 1 %h %h", i, if_id_valid, if_id_pc, if_id_instr, e.pc, e.instr);
            else pass_cnt++;
            total_cnt++;
            if (opcode !== e.instr[15:11])
                $display("FAIL stream_opcode[%0d]: got %h, want %h", i, opcode, e.instr[15:11]);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        exp_t e;
        sb.push_back('{pc: 8'h04, instr: mem_word(8'h04)});
        @(negedge clk);
        e = sb.pop_front();
        total_cnt++;
        if (if_id_valid !== 1'b1 || if_id_pc !== e.pc || if_id_instr !== e.instr)
            $display("FAIL stall_pre: valid=%b pc=%h instr=%h, want 1 %h %h", if_id_valid, if_id_pc, if_id_instr, e.pc, e.instr);
        else pass_cnt++;
        stall = 1'b1;
        sb.push_back('{pc: 8'h05, instr: mem_word(8'h05)});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({if_id_valid, if_id_pc, if_id_instr, imem_req} !== {1'b1, e.pc, e.instr, 1'b0})
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h req=%b, want 1 %h %h 0",
                         i, if_id_valid, if_id_pc, if_id_instr, imem_req, e.pc, e.instr);
            else pass_cnt++;
        end
        stall = 1'b0;
        sb.push_back('{pc: 8'h06, instr: mem_word(8'h06)});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            total_cnt++;
            if (if_id_valid !== 1'b1 || if_id_pc !== e.pc || if_id_instr !== e.instr)
                $display("FAIL stall_release[%0d]: valid=%b pc=%h instr=%h, want 1 %h %h", i, if_id_valid, if_id_pc, if_id_instr, e.pc, e.instr);
            else pass_cnt++;
        end
    endtask

    task automatic test_flush();
        exp_t e;
        imem_ready = 1'b0;
        flush = 1'b1;
        branch_target = 8'h33;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) branch_target = 8'h40;
            else flush = 1'b0;
            total_cnt++;
            if ({if_id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 8'h07})
                $display("FAIL flush_discard[%0d]: valid=%b req=%b addr=%h, want 0 1 07", i, if_id_valid, imem_req, imem_addr);
            else pass_cnt++;
        end
        imem_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({if_id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 8'h40})
            $display("FAIL flush_redirect: valid=%b req=%b addr=%h, want 0 1 40", if_id_valid, imem_req, imem_addr);
        else pass_cnt++;
        sb.push_back('{pc: 8'h40, instr: mem_word(8'h40)});
        @(negedge clk);
        e = sb.pop_front();
        total_cnt++;
        if (if_id_valid !== 1'b1 || if_id_pc !== e.pc || if_id_instr !== e.instr)
            $display("FAIL flush_target_fetch: valid=%b pc=%h instr=%h, want 1 %h %h", if_id_valid, if_id_pc, if_id_instr, e.pc, e.instr);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        exp_t e;
        halt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            halt = 1'b0;
            total_cnt++;
            if ({imem_req, if_id_valid, imem_addr} !== {1'b0, 1'b0, 8'h41})
                $display("FAIL halted[%0d]: req=%b valid=%b addr=%h, want 0 0 41", i, imem_req, if_id_valid, imem_addr);
            else pass_cnt++;
        end
        flush = 1'b1;
        branch_target = 8'h10;
        @(negedge clk);
        flush = 1'b0;
        total_cnt++;
        if ({imem_req, if_id_valid, imem_addr} !== {1'b1, 1'b0, 8'h10})
            $display("FAIL halt_exit: req=%b valid=%b addr=%h, want 1 0 10", imem_req, if_id_valid, imem_addr);
        else pass_cnt++;
        sb.push_back('{pc: 8'h10, instr: mem_word(8'h10)});
        @(negedge clk);
        e = sb.pop_front();
        total_cnt++;
        if (if_id_valid !== 1'b1 || if_id_pc !== e.pc || if_id_instr !== e.instr)
            $display("FAIL halt_resume: valid=%b pc=%h instr=%h, want 1 %h %h", if_id_valid, if_id_pc, if_id_instr, e.pc, e.instr);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        exp_t e;
        flush = 1'b1;
        branch_target = 8'hFE;
        @(negedge clk);
        flush = 1'b0;
        total_cnt++;
        if ({if_id_valid, imem_addr} !== {1'b0, 8'hFE})
            $display("FAIL wrap_redirect: valid=%b addr=%h, want 0 fe", if_id_valid, imem_addr);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) sb.push_back('{pc: 8'(8'hFE + i), instr: mem_word(8'(8'hFE + i))});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            total_cnt++;
            if (if_id_valid !== 1'b1 || if_id_pc !== e.pc || if_id_instr !== e.instr)
                $display("FAIL wrap[%0d]: valid=%b pc=%h instr=%h, want 1 %h %h", i, if_id_valid, if_id_pc, if_id_instr, e.pc, e.instr);
            else pass_cnt++;
            if (i == 1) begin
                total_cnt++;
                if (imem_addr !== 8'h00)
                    $display("FAIL wrap_addr: addr=%h, want 00", imem_addr);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({imem_req, if_id_valid, if_id_instr, if_id_pc, imem_addr} !== {1'b0, 1'b0, 16'h0000, 8'h00, 8'h00})
            $display("FAIL async_reset: req=%b valid=%b instr=%h pc=%h addr=%h, want 0 0 0000 00 00",
                     imem_req, if_id_valid, if_id_instr, if_id_pc, imem_addr);
        else pass_cnt++;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({imem_req, if_id_valid, imem_addr} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL async_release: req=%b valid=%b addr=%h, want 1 0 00", imem_req, if_id_valid, imem_addr);
        else pass_cnt++;
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({perf_fetch_cnt, perf_stall_cnt} !== 32'h0)
            $display("FAIL perf_reset: fetch=%0d stall=%0d, want 0 0", perf_fetch_cnt, perf_stall_cnt);
        else pass_cnt++;
        rst_n = 1'b1;
        imem_ready = 1'b1;
        repeat (6) @(negedge clk);
        stall = 1'b1;
        imem_ready = 1'b0;
        repeat (2) @(negedge clk);
        stall = 1'b0;
        total_cnt++;
        if ({perf_fetch_cnt, perf_stall_cnt} !== {16'd5, 16'd2})
            $display("FAIL perf_counts: fetch=%0d stall=%0d, want 5 2", perf_fetch_cnt, perf_stall_cnt);
        else pass_cnt++;
        imem_ready = 1'b1;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_halt();
        test_wrap();
        test_async_reset();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
